// File: rtl/spart_mmio_bridge.sv
// CPU-to-SPART memory-mapped bridge: decodes the SPART data/status words and runs the
// valid/ready handshake. Optional BUSY watchdog enabled by SPART_MMIO_TIMEOUT_EN.
module spart_mmio_bridge #(
    parameter logic [27:0] BASE_ADDR      = 28'h800_0000,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [27:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic        io_rw_data,
    output logic        io_valid_data,
    input  logic        io_ready_data,
    output logic [27:0] mem_addr,
    output logic [31:0] io_wr_data,
    input  logic [31:0] io_rd_data
);
    typedef enum logic [1:0] {IDLE, BUSY, ACK, GAP} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_rw, w_rw_nxt;
    logic [27:0] r_addr, w_addr_nxt;
    logic [31:0] r_wdata, w_wdata_nxt;
    logic [31:0] r_rdata, w_rdata_nxt;
    logic        r_err, w_err_nxt;
    logic        w_mapped;
    logic        w_timeout;

    // Status word is read-only, so a write to it is treated like an unmapped access.
    assign w_mapped = (cpu_addr == BASE_ADDR) ||
                      ((cpu_addr == BASE_ADDR + 28'd1) && !cpu_we);

`ifdef SPART_MMIO_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = TIMEOUT_CYCLES - 16'd1;
    logic [15:0] r_tmo_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_tmo_cnt <= 16'd0;
        else if (r_state == IDLE)
            r_tmo_cnt <= 16'd0;
        else if (r_state == BUSY && !io_ready_data)
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end

    assign w_timeout = (r_state == BUSY) && (r_tmo_cnt == TMO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_rw_nxt    = r_rw;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_rdata_nxt = r_rdata;
        w_err_nxt   = r_err;
        case (r_state)
            IDLE: begin
                if (cpu_req) begin
                    if (w_mapped) begin
                        w_rw_nxt    = cpu_we;
                        w_addr_nxt  = cpu_addr;
                        w_wdata_nxt = cpu_wdata;
                        w_state_nxt = BUSY;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_rdata_nxt = 32'd0;
                        w_state_nxt = ACK;
                    end
                end
            end
            BUSY: begin
                // Ready takes priority over a watchdog expiring on the same edge.
                if (io_ready_data) begin
                    w_rdata_nxt = r_rw ? 32'd0 : io_rd_data;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = ACK;
                end else if (w_timeout) begin
                    w_rdata_nxt = 32'd0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ACK;
                end
            end
            ACK:     w_state_nxt = GAP;
            GAP:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_rw    <= 1'b0;
            r_addr  <= 28'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rw    <= w_rw_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_rdata <= w_rdata_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Handshake strobes are decoded from the state register only, so they stay registered.
    assign io_valid_data = (r_state == BUSY);
    assign cpu_ack       = (r_state == ACK);
    assign cpu_err       = r_err;
    assign cpu_rdata     = r_rdata;
    assign io_rw_data    = r_rw;
    assign mem_addr      = r_addr;
    assign io_wr_data    = r_wdata;
endmodule

// File: doc/spart_mmio_bridge.md
# spart_mmio_bridge

Memory-mapped bridge between the processor's data-memory stage and `spart_top_level`. It decodes CPU accesses in the SPART I/O window (`28'h800_0000` data, `28'h800_0001` status) and drives the `io_valid_data`/`io_ready_data` handshake. It holds each request stable until the SPART side acknowledges, then returns read data and a one-cycle acknowledge to the CPU. Unmapped, illegal or stalled accesses complete with an error flag instead of hanging the pipeline.

## Interface
Parameters:
- `BASE_ADDR`, `28'h800_0000`, word address of the SPART data register; status register is `BASE_ADDR+1`.
- `TIMEOUT_CYCLES`, `16'd1024`, maximum cycles a request waits for `io_ready_data`; legal range 2..65535.

Ports:
- `clk`  in  1  system clock (100 MHz); one clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `cpu_req`  in  1  CPU access request; held high until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  28  word address.
- `cpu_wdata`  in  32  write data.
- `cpu_rdata`  out  32  read data, valid while `cpu_ack` is high.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_err`  out  1  qualifies `cpu_ack`: access failed.
- `io_rw_data`  out  1  to SPART: 1 = write.
- `io_valid_data`  out  1  to SPART: request valid.
- `io_ready_data`  in  1  from SPART: request complete.
- `mem_addr`  out  28  to SPART: register address.
- `io_wr_data`  out  32  to SPART: write data.
- `io_rd_data`  in  32  from SPART: read data.

## Operation
- FSM states: IDLE, BUSY, ACK, GAP.
- IDLE: `cpu_req` is sampled only in this state.
  - Read of `BASE_ADDR` or `BASE_ADDR+1`, or write of `BASE_ADDR`: latch `cpu_we`, `cpu_addr` and `cpu_wdata` into `io_rw_data`, `mem_addr` and `io_wr_data`. Clear the timeout counter and go to BUSY.
  - Write of `BASE_ADDR+1` (status is read-only), or any other address: set error, set rdata to 0, go to ACK. No SPART access is made.
- BUSY: `io_valid_data` = 1 and the request outputs are held constant.
  - `io_ready_data` = 1: capture `io_rd_data` into `cpu_rdata` (reads only; writes load 0) and go to ACK with error = 0.
  - Otherwise, increment the timeout counter (see Configuration).
- ACK: `cpu_ack` = 1 for exactly one cycle and `io_valid_data` = 0. Next state is GAP.
- GAP: one mandatory idle cycle with `io_valid_data` = 0. This guarantees the SPART handshake-phase counter returns to 0 before the next request. Next state is IDLE.
- All outputs are registered; none depends combinationally on inputs.
- `cpu_rdata` and `cpu_err` hold their values from ACK until the next ACK.

## Timing
- Reset values: state = IDLE; `cpu_ack`, `cpu_err`, `io_valid_data` and `io_rw_data` = 0; `cpu_rdata`, `mem_addr` and `io_wr_data` = 0; timeout counter = 0.
- Mapped access with request sampled at edge N:
  - `io_valid_data` high from N+1.
  - If `io_ready_data` is sampled high at edge M, `cpu_ack` is high in cycle M+1.
  - Minimum request-to-ack latency is 2 cycles; back-to-back throughput is one access per 4 cycles minimum.
- Error access with request sampled at edge N: `cpu_ack` and `cpu_err` high in cycle N+1.
- `io_ready_data` is ignored in IDLE, ACK and GAP.
- `cpu_req` deasserted by the CPU mid-BUSY: the transaction still completes, because the SPART side cannot be aborted.
- Reset asserted mid-BUSY: all outputs clear immediately (asynchronous), and any in-flight SPART transaction is dropped.
- Timeout expiry and `io_ready_data` on the same edge: ready wins, and the access completes with error = 0.

## Configuration
- `SPART_MMIO_TIMEOUT_EN` defined:
  - A 16-bit counter runs in BUSY.
  - When the counter reaches `TIMEOUT_CYCLES-1` without ready, `io_valid_data` drops and the FSM goes to ACK with `cpu_err` = 1 and `cpu_rdata` = 0.
- Not defined:
  - No counter is instantiated, and BUSY waits indefinitely for `io_ready_data`.
  - `TIMEOUT_CYCLES` is unused.

## Test plan
- Reset: hold `rst` for 3 cycles mid-BUSY → all outputs 0 on the cycle `rst` rises; state IDLE after release.
- Read `28'h800_0000`, SPART returns `io_rd_data` = `32'h0000_0041` with ready 3 cycles after valid → `cpu_ack` 1 cycle later, `cpu_rdata` = `32'h41`, `cpu_err` = 0, valid low for ≥2 cycles before the next request.
- Write `32'h0000_005A` to `28'h800_0000` → `io_rw_data` = 1, `io_wr_data` = `32'h5A` stable while valid; ack with `cpu_err` = 0.
- Write to `28'h800_0001` and read of `28'h000_1000` → ack the next cycle with `cpu_err` = 1, `cpu_rdata` = 0; `io_valid_data` never asserts.
- With `SPART_MMIO_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 8, ready never asserted → valid high for exactly 8 cycles, then ack with `cpu_err` = 1. Second run with ready on the 8th cycle → `cpu_err` = 0.
- Back-to-back reads of status then data with `cpu_req` held → two acks separated by at least 4 cycles; each SPART request preceded by a valid-low GAP cycle.
